turfio_cmd_assembler: RTL and testbench

TURFIO_CMD_ASSEMBLER -- requirements
Module: turfio_cmd_assembler

---
 rtl/turfio_cmd_pkg.sv | 15 +
 rtl/turfio_ce_gap_check.sv | 33 +++
 rtl/turfio_cmd_assembler.sv | 98 +++++++++
 tb/tb_turfio_cmd_assembler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/turfio_cmd_pkg.sv
// Shared types and constants for the TURFIO command assembler.
// Holds the lock FSM encoding, word geometry and default training word.
package turfio_cmd_pkg;

   localparam int CMD_WIDTH = 32;
   localparam int NIBBLES   = 8;
   localparam logic [CMD_WIDTH-1:0] TRAIN_PATTERN_DEFAULT = 32'hA55A6996;

   typedef enum logic [1:0] {
      ST_DISABLED,
      ST_HUNT,
      ST_LOCKED
   } state_t;

endpackage

// File: rtl/turfio_ce_gap_check.sv
// Measures aclk cycles between nibble strobes; combinational violation flag on a
// strobe whose gap differs from CE_PERIOD while checking is enabled. No backpressure.
module turfio_ce_gap_check #(
   parameter int CE_PERIOD = 3
) (
   input  logic aclk_i,
   input  logic aresetn_i,
   input  logic ce_i,
   input  logic check_i,
   output logic viol_o
);

   // One spare bit so the saturated value can never alias CE_PERIOD.
   localparam int CW = $clog2(CE_PERIOD + 2) + 1;
   localparam logic [CW-1:0] GAP_MAX = '1;
   localparam logic [CW-1:0] PERIOD  = CW'(CE_PERIOD);

   logic [CW-1:0] gap_cnt;

   // Every strobe restarts the count, so the cycle after a strobe reads 1.
   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         gap_cnt <= '0;
      end else if (ce_i) begin
         gap_cnt <= CW'(1);
      end else if (gap_cnt != GAP_MAX) begin
         gap_cnt <= gap_cnt + CW'(1);
      end
   end

   assign viol_o = ce_i & check_i & (gap_cnt != PERIOD);

endmodule

// File: rtl/turfio_cmd_assembler.sv
// Assembles 32-bit commands from a nibble stream after locking on a training word.
// Outputs registered one cycle after the completing strobe; no backpressure, words are pulsed out.
module turfio_cmd_assembler
   import turfio_cmd_pkg::*;
#(
   parameter logic [CMD_WIDTH-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
   parameter int                   CE_PERIOD     = 3
) (
   input  logic                 aclk_i,
   input  logic                 aresetn_i,
   input  logic                 en_i,
   input  logic [3:0]           data_i,
   input  logic                 data_ce_i,
   input  logic                 capture_err_i,
   output logic [CMD_WIDTH-1:0] cmd_o,
   output logic                 cmd_valid_o,
   output logic                 locked_o,
   output logic                 ce_err_o,
   output logic [15:0]          err_count_o
);

   localparam int NW = $clog2(NIBBLES);
   localparam logic [NW-1:0] LAST_NIB = NW'(NIBBLES - 1);

   state_t               state;
   logic [CMD_WIDTH-1:0] sr;
   logic [CMD_WIDTH-1:0] sr_next;
   logic [NW-1:0]        nib_cnt;
   logic                 gap_viol;

   assign sr_next = {sr[CMD_WIDTH-5:0], data_i};

   turfio_ce_gap_check #(
      .CE_PERIOD (CE_PERIOD)
   ) u_gap_check (
      .aclk_i    (aclk_i),
      .aresetn_i (aresetn_i),
      .ce_i      (data_ce_i),
      .check_i   (state == ST_LOCKED),
      .viol_o    (gap_viol)
   );

   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state       <= ST_DISABLED;
         sr          <= '0;
         nib_cnt     <= '0;
         cmd_o       <= '0;
         cmd_valid_o <= 1'b0;
         locked_o    <= 1'b0;
         ce_err_o    <= 1'b0;
         err_count_o <= '0;
      end else begin
         cmd_valid_o <= 1'b0;
         ce_err_o    <= 1'b0;
         if (!en_i) begin
            state    <= ST_DISABLED;
            sr       <= '0;
            nib_cnt  <= '0;
            locked_o <= 1'b0;
         end else begin
            case (state)
               ST_DISABLED: state <= ST_HUNT;
               ST_HUNT: begin
                  if (data_ce_i) begin
                     sr <= sr_next;
                     if (sr_next == TRAIN_PATTERN) begin
                        state    <= ST_LOCKED;
                        nib_cnt  <= '0;
                        locked_o <= 1'b1;
                     end
                  end
               end
               ST_LOCKED: begin
                  // Errors take priority over a completing strobe; the partial word is dropped.
                  if (capture_err_i || gap_viol) begin
                     state    <= ST_HUNT;
                     sr       <= '0;
                     nib_cnt  <= '0;
                     locked_o <= 1'b0;
                     ce_err_o <= gap_viol;
                     if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
                  end else if (data_ce_i) begin
                     sr      <= sr_next;
                     nib_cnt <= nib_cnt + NW'(1);
                     if (nib_cnt == LAST_NIB && sr_next != TRAIN_PATTERN) begin
                        cmd_o       <= sr_next;
                        cmd_valid_o <= 1'b1;
                     end
                  end
               end
               default: state <= ST_DISABLED;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_turfio_cmd_assembler.sv
// Randomized bench for turfio_cmd_assembler: nibble-stream reference model feeds
// a scoreboard of expected command words and CE-error pulses.
module tb_turfio_cmd_assembler;

   localparam logic [31:0] TRAIN  = 32'hA55A6996;
   localparam int          PERIOD = 3;

   logic        aclk_i = 1'b0;
   logic        aresetn_i;
   logic        en_i;
   logic [3:0]  data_i;
   logic        data_ce_i;
   logic        capture_err_i;
   logic [31:0] cmd_o;
   logic        cmd_valid_o;
   logic        locked_o;
   logic        ce_err_o;
   logic [15:0] err_count_o;

   turfio_cmd_assembler #(
      .TRAIN_PATTERN (TRAIN),
      .CE_PERIOD     (PERIOD)
   ) dut (
      .aclk_i        (aclk_i),
      .aresetn_i     (aresetn_i),
      .en_i          (en_i),
      .data_i        (data_i),
      .data_ce_i     (data_ce_i),
      .capture_err_i (capture_err_i),
      .cmd_o         (cmd_o),
      .cmd_valid_o   (cmd_valid_o),
      .locked_o      (locked_o),
      .ce_err_o      (ce_err_o),
      .err_count_o   (err_count_o)
   );

   always #5 aclk_i = ~aclk_i;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic en_r   = 1'b0;

   // Reference model: mode 0=off, 1=hunting, 2=locked.
   int          m_mode = 0;
   logic [3:0]  hist[$];
   logic [3:0]  wq[$];
   int          last_ce = 0;
   int          m_err = 0;
   logic [31:0] m_cmd = '0;

   logic [31:0] exp_cmd[$];
   int          exp_cmd_t[$];
   int          exp_ce_t[$];

   function automatic logic [31:0] pack(input logic [3:0] q[$]);
      logic [31:0] v = '0;
      foreach (q[i]) v = {v[27:0], q[i]};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   task automatic model(input logic ce, input logic [3:0] d, input logic cerr);
      logic bad_gap;
      if (!en_r) begin
         m_mode = 0;
         hist.delete();
         wq.delete();
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (ce) begin
            hist.push_back(d);
            if (hist.size() > 8) void'(hist.pop_front());
            if (hist.size() == 8 && pack(hist) == TRAIN) begin
               m_mode  = 2;
               wq.delete();
               last_ce = cyc;
            end
         end
      end else begin
         bad_gap = ce && (cyc - last_ce != PERIOD);
         if (cerr || bad_gap) begin
            m_mode = 1;
            hist.delete();
            wq.delete();
            if (m_err < 65535) m_err++;
            if (bad_gap) exp_ce_t.push_back(cyc);
         end else if (ce) begin
            last_ce = cyc;
            wq.push_back(d);
            if (wq.size() == 8) begin
               if (pack(wq) != TRAIN) begin
                  m_cmd = pack(wq);
                  exp_cmd.push_back(m_cmd);
                  exp_cmd_t.push_back(cyc);
               end
               wq.delete();
            end
         end
      end
   endtask

   task automatic step(input logic ce, input logic [3:0] d, input logic cerr);
      en_i          = en_r;
      data_ce_i     = ce;
      data_i        = d;
      capture_err_i = cerr;
      @(posedge aclk_i);
      cyc++;
      model(ce, d, cerr);
      #1;
      check("locked_o", 32'(locked_o), 32'(m_mode == 2));
      check("err_count_o", 32'(err_count_o), 32'(m_err));
      check("cmd_o_hold", cmd_o, m_cmd);
      data_ce_i     = 1'b0;
      capture_err_i = 1'b0;
   endtask

   task automatic send_nib(input logic [3:0] d, input int gap, input logic cerr);
      for (int i = 1; i < gap; i++) step(1'b0, 4'($urandom), 1'b0);
      step(1'b1, d, cerr);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 7; i >= 0; i--) send_nib(w[i*4 +: 4], PERIOD, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), 1'b0);
   endtask

   task automatic apply_reset();
      aresetn_i = 1'b0;
      #1;
      check("rst cmd_o", cmd_o, 32'h0);
      check("rst cmd_valid_o", 32'(cmd_valid_o), 32'h0);
      check("rst locked_o", 32'(locked_o), 32'h0);
      check("rst ce_err_o", 32'(ce_err_o), 32'h0);
      check("rst err_count_o", 32'(err_count_o), 32'h0);
      m_mode = 0; m_err = 0; m_cmd = '0;
      hist.delete(); wq.delete();
      exp_cmd.delete(); exp_cmd_t.delete(); exp_ce_t.delete();
      @(posedge aclk_i); cyc++;
      @(posedge aclk_i); cyc++;
      #1 aresetn_i = 1'b1;
   endtask

   // Scoreboard monitor on the falling edge, away from the active edge.
   always @(negedge aclk_i) begin
      if (aresetn_i === 1'b1) begin
         if (cmd_valid_o) begin
            checks++;
            if (exp_cmd.size() == 0) begin
               failures++;
               $display("FAIL cmd_unexpected cycle=%0d actual=%h required=none", cyc, cmd_o);
            end else begin
               logic [31:0] w;
               int t;
               w = exp_cmd.pop_front();
               t = exp_cmd_t.pop_front();
               if (w !== cmd_o || t != cyc) begin
                  failures++;
                  $display("FAIL cmd_word cycle=%0d actual=%h required=%h@%0d", cyc, cmd_o, w, t);
               end
            end
         end else if (exp_cmd_t.size() != 0 && exp_cmd_t[0] <= cyc) begin
            checks++;
            failures++;
            $display("FAIL cmd_missing cycle=%0d actual=none required=%h", cyc, exp_cmd[0]);
            void'(exp_cmd.pop_front());
            void'(exp_cmd_t.pop_front());
         end
         if (ce_err_o) begin
            checks++;
            if (exp_ce_t.size() == 0 || exp_ce_t[0] != cyc) begin
               failures++;
               $display("FAIL ce_err_unexpected cycle=%0d actual=1 required=0", cyc);
            end
            if (exp_ce_t.size() != 0) void'(exp_ce_t.pop_front());
         end else if (exp_ce_t.size() != 0 && exp_ce_t[0] <= cyc) begin
            checks++;
            failures++;
            $display("FAIL ce_err_missing cycle=%0d actual=0 required=1", cyc);
            void'(exp_ce_t.pop_front());
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      aresetn_i = 1'b1; en_i = 1'b0; data_i = '0; data_ce_i = 1'b0; capture_err_i = 1'b0;
      #2;
      apply_reset();
      en_r = 1'b1;
      idle(4);

      // Basic lock and one command.
      send_word(TRAIN);
      send_word(32'h12345678);
      idle(5);

      // Junk before training, then a new word.
      en_r = 1'b0; idle(2); en_r = 1'b1; idle(2);
      send_nib(4'h3, PERIOD, 1'b0); send_nib(4'hC, PERIOD, 1'b0); send_nib(4'h0, PERIOD, 1'b0);
      send_word(TRAIN);
      send_word(32'hDEADBEEF);

      // Gap of 4 mid-word.
      for (int i = 7; i >= 0; i--) send_nib(4'(i), (i == 4) ? 4 : PERIOD, 1'b0);
      idle(4);

      // Capture error on the completing strobe.
      send_word(TRAIN);
      for (int i = 7; i >= 0; i--) send_nib(4'(i + 1), PERIOD, i == 0);
      idle(4);

      // Training word while locked is swallowed.
      send_word(TRAIN);
      send_word(TRAIN);
      send_word(32'h00000001);

      // Enable drop mid-word, then relock.
      for (int i = 0; i < 3; i++) send_nib(4'hF, PERIOD, 1'b0);
      en_r = 1'b0; idle(2); en_r = 1'b1; idle(2);
      send_word(TRAIN);
      send_word(32'hCAFE0123);

      // Randomized traffic.
      for (int n = 0; n < 250; n++) begin
         logic [31:0] w;
         w = ($urandom_range(0, 99) < 20) ? TRAIN : $urandom;
         for (int i = 7; i >= 0; i--) begin
            int g;
            g = PERIOD;
            if ($urandom_range(0, 39) == 0) g = ($urandom_range(0, 1) != 0) ? PERIOD + 1 : PERIOD - 1;
            send_nib(w[i*4 +: 4], g, $urandom_range(0, 299) == 0);
         end
         if ($urandom_range(0, 59) == 0) begin
            en_r = 1'b0; idle(2); en_r = 1'b1;
         end
      end
      idle(4);

      // Reset mid-word; data without training must not produce commands.
      send_word(TRAIN);
      for (int i = 0; i < 4; i++) send_nib(4'h5, PERIOD, 1'b0);
      apply_reset();
      for (int n = 0; n < 4; n++) send_word($urandom);
      idle(4);

      checks++;
      if (exp_cmd.size() != 0 || exp_ce_t.size() != 0) begin
         failures++;
         $display("FAIL pending_expectations actual=%0d/%0d required=0/0", exp_cmd.size(), exp_ce_t.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
